// File: rtl/tmr_pkg.sv
// Shared types for the TMR SRAM scrub controller.
// Scrub FSM encoding and default counter width.
package tmr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_WB
  } scrub_state_e;

  localparam int unsigned CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/tmr_vote.sv
// Three-way bitwise majority vote over the raw SRAM copies.
// Flags any disagreement and the no-two-equal case.
module tmr_vote #(
  parameter int unsigned DW = 64
) (
  input  logic [DW-1:0] i_r0,
  input  logic [DW-1:0] i_r1,
  input  logic [DW-1:0] i_r2,
  output logic [DW-1:0] o_voted,
  output logic          o_mismatch,
  output logic          o_uncorr
);

  logic w_ne01;
  logic w_ne12;
  logic w_ne02;

  assign w_ne01 = (i_r0 != i_r1);
  assign w_ne12 = (i_r1 != i_r2);
  assign w_ne02 = (i_r0 != i_r2);

  assign o_voted    = (i_r0 & i_r1) | (i_r1 & i_r2) | (i_r0 & i_r2);
  assign o_mismatch = w_ne01 | w_ne12;
  assign o_uncorr   = w_ne01 & w_ne12 & w_ne02;

endmodule

// File: rtl/tmr_sram_scrub_ctrl.sv
// Client passthrough with voted reads plus an idle-cycle
// background scrubber that repairs single-copy upsets.
module tmr_sram_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned SCRUB_INTERVAL = 256,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  localparam int unsigned AW = $clog2(NUM_WORDS),
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scrub_en_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BW-1:0]         be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata0_i,
  input  logic [DATA_WIDTH-1:0] sram_rdata1_i,
  input  logic [DATA_WIDTH-1:0] sram_rdata2_i,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic                  uncorr_o,
  output logic                  pass_done_o
);

  localparam int unsigned IW = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [IW-1:0] ILAST = IW'(SCRUB_INTERVAL - 1);
  localparam logic [AW-1:0] ALAST = AW'(NUM_WORDS - 1);

  scrub_state_e r_state;
  scrub_state_e w_next;

  logic [AW-1:0]         r_addr;
  logic [IW-1:0]         r_icnt;
  logic [CNT_WIDTH-1:0]  r_corr;
  logic [CNT_WIDTH-1:0]  r_ucnt;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_rvalid;
  logic                  r_uncorr;
  logic                  r_pass;

  logic [DATA_WIDTH-1:0] w_sc_voted;
  logic                  w_sc_mis;
  logic                  w_sc_unc;
  logic [DATA_WIDTH-1:0] w_cl_voted;
  logic                  w_cl_mis;
  logic                  w_cl_unc;
  logic                  w_unused_cl;
  logic                  w_cl_hit;
  logic                  w_adv;
  logic                  w_inc_corr;
  logic                  w_inc_unc;
  logic                  w_latch;

  tmr_vote #(.DW(DATA_WIDTH)) u_vote_scrub (
    .i_r0       (sram_rdata0_i),
    .i_r1       (sram_rdata1_i),
    .i_r2       (sram_rdata2_i),
    .o_voted    (w_sc_voted),
    .o_mismatch (w_sc_mis),
    .o_uncorr   (w_sc_unc)
  );

  tmr_vote #(.DW(DATA_WIDTH)) u_vote_client (
    .i_r0       (sram_rdata0_i),
    .i_r1       (sram_rdata1_i),
    .i_r2       (sram_rdata2_i),
    .o_voted    (w_cl_voted),
    .o_mismatch (w_cl_mis),
    .o_uncorr   (w_cl_unc)
  );

  // Client reads only need the voted word.
  assign w_unused_cl = w_cl_mis ^ w_cl_unc;

  assign w_cl_hit = req_i & we_i & (addr_i == r_addr);

  assign gnt_o        = req_i;
  assign rvalid_o     = r_rvalid;
  assign rdata_o      = w_cl_voted;
  assign corr_cnt_o   = r_corr;
  assign uncorr_cnt_o = r_ucnt;
  assign uncorr_o     = r_uncorr;
  assign pass_done_o  = r_pass;

  // Scrub FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Scrub FSM next-state logic; client traffic stalls RD and WB.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (scrub_en_i && r_icnt == ILAST) w_next = S_RD;
      S_RD:   if (!req_i) w_next = S_CHK;
      S_CHK:  begin
        if (w_sc_mis && !w_sc_unc && !w_cl_hit) w_next = S_WB;
        else                                    w_next = S_IDLE;
      end
      S_WB:   if (!req_i || w_cl_hit) w_next = S_IDLE;
    endcase
  end

  // SRAM port mux and scrub actions; client always has priority.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    w_adv        = 1'b0;
    w_inc_corr   = 1'b0;
    w_inc_unc    = 1'b0;
    w_latch      = 1'b0;
    if (req_i) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i;
      sram_addr_o  = addr_i;
      sram_wdata_o = wdata_i;
      sram_be_o    = be_i;
    end
    unique case (r_state)
      S_IDLE: ;
      S_RD: begin
        if (!req_i) begin
          sram_req_o  = 1'b1;
          sram_addr_o = r_addr;
        end
      end
      S_CHK: begin
        if (!w_sc_mis) begin
          w_adv = 1'b1;
        end else if (w_sc_unc) begin
          w_adv     = 1'b1;
          w_inc_unc = 1'b1;
        end else if (w_cl_hit) begin
          w_adv = 1'b1;
        end else begin
          w_latch = 1'b1;
        end
      end
      S_WB: begin
        if (!req_i) begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = r_addr;
          sram_wdata_o = r_wb_data;
          sram_be_o    = '1;
          w_adv        = 1'b1;
          w_inc_corr   = 1'b1;
        end else if (w_cl_hit) begin
          w_adv = 1'b1;
        end
      end
    endcase
  end

  // Interval counter runs only while idle and enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_icnt <= '0;
    end else if (!scrub_en_i) begin
      r_icnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (r_icnt == ILAST) r_icnt <= '0;
      else                 r_icnt <= r_icnt + IW'(1);
    end
  end

  // Scrub address walk and end-of-pass pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      r_pass <= 1'b0;
    end else begin
      r_pass <= w_adv && (r_addr == ALAST);
      if (w_adv) begin
        if (r_addr == ALAST) r_addr <= '0;
        else                 r_addr <= r_addr + AW'(1);
      end
    end
  end

  // Voted word held for the writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_wb_data <= '0;
    else if (w_latch) r_wb_data <= w_sc_voted;
  end

  // Saturating repair / uncorrectable counters and pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_corr   <= '0;
      r_ucnt   <= '0;
      r_uncorr <= 1'b0;
    end else begin
      r_uncorr <= w_inc_unc;
      if (w_inc_corr && r_corr != '1) r_corr <= r_corr + CNT_WIDTH'(1);
      if (w_inc_unc && r_ucnt != '1)  r_ucnt <= r_ucnt + CNT_WIDTH'(1);
    end
  end

  // Client read data is valid one cycle after a granted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rvalid <= 1'b0;
    else         r_rvalid <= req_i & ~we_i;
  end

endmodule

// File: tb/tb_tmr_sram_scrub_ctrl.sv
// Scoreboard bench for tmr_sram_scrub_ctrl with a 3-copy
// SRAM model; expected reads/writes are queued and checked.
module tb_tmr_sram_scrub_ctrl;

  localparam int DW = 64;
  localparam int NW = 8;
  localparam int AW = 3;
  localparam int BW = 8;
  localparam int CW = 16;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be = '0;

  logic          gnt, rvalid, s_req, s_we, unc, pass;
  logic [DW-1:0] rdata, s_wdata;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [CW-1:0] corr_cnt, unc_cnt;
  logic [DW-1:0] rd0 = '0, rd1 = '0, rd2 = '0;

  logic [DW-1:0] m0 [NW] = '{default: '0};
  logic [DW-1:0] m1 [NW] = '{default: '0};
  logic [DW-1:0] m2 [NW] = '{default: '0};

  logic          inj_v = 1'b0;
  int            inj_c = 0;
  logic [AW-1:0] inj_a = '0;
  logic [DW-1:0] inj_d = '0;

  logic [DW-1:0] exp_rd [$];
  wr_t           exp_wr [$];

  int n_tests = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_unc = 0;
  int n_pass = 0;
  bit prev_rd = 1'b0;

  tmr_sram_scrub_ctrl #(
    .DATA_WIDTH     (DW),
    .NUM_WORDS      (NW),
    .SCRUB_INTERVAL (4),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .scrub_en_i    (scrub_en),
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .be_i          (be),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .sram_req_o    (s_req),
    .sram_we_o     (s_we),
    .sram_addr_o   (s_addr),
    .sram_wdata_o  (s_wdata),
    .sram_be_o     (s_be),
    .sram_rdata0_i (rd0),
    .sram_rdata1_i (rd1),
    .sram_rdata2_i (rd2),
    .corr_cnt_o    (corr_cnt),
    .uncorr_cnt_o  (unc_cnt),
    .uncorr_o      (unc),
    .pass_done_o   (pass)
  );

  always #5 clk = ~clk;

  // Three SRAM copies sharing one port, plus upset injection.
  always @(posedge clk) begin
    if (inj_v) begin
      case (inj_c)
        0:       m0[inj_a] <= inj_d;
        1:       m1[inj_a] <= inj_d;
        default: m2[inj_a] <= inj_d;
      endcase
    end
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < BW; b++) begin
          if (s_be[b]) begin
            m0[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
            m1[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
            m2[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
          end
        end
      end else begin
        rd0 <= m0[s_addr];
        rd1 <= m1[s_addr];
        rd2 <= m2[s_addr];
      end
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0;
    end else begin
      chk("rvalid_latency", rvalid, prev_rd);
      if (rvalid) begin
        if (exp_rd.size() == 0) chk("rdata_unexpected", 1, 0);
        else chk("rdata", rdata, exp_rd.pop_front());
      end
      prev_rd = req & ~we;
      if (req) begin
        chk("pass_addr", s_addr, addr);
        chk("pass_we", s_we, we);
        if (we) chk("pass_wdata", s_wdata, wdata);
        if (we) chk("pass_be", s_be, be);
      end else if (s_req) begin
        if (!s_we) begin
          n_rd++;
        end else if (exp_wr.size() == 0) begin
          chk("scrub_wr_unexpected", s_addr, 7'h7f);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("scrub_wr_addr", s_addr, e.a);
          chk("scrub_wr_data", s_wdata, e.d);
          chk("scrub_wr_be", s_be, e.be);
        end
      end
      if (unc) n_unc++;
      if (pass) n_pass++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cli(bit w, int a, logic [DW-1:0] d,
                     logic [BW-1:0] b, logic [DW-1:0] e);
    req = 1'b1;
    we = w;
    addr = AW'(a);
    wdata = d;
    be = b;
    if (!w) exp_rd.push_back(e);
    cyc();
    req = 1'b0;
    we = 1'b0;
  endtask

  task automatic inject(int c, int a, logic [DW-1:0] d);
    inj_c = c;
    inj_a = AW'(a);
    inj_d = d;
    inj_v = 1'b1;
    cyc();
    inj_v = 1'b0;
  endtask

  task automatic wait_pass();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (pass) ok = 1'b1;
    end
    #1;
    chk("pass_done_timeout", ok, 1);
  endtask

  task automatic wait_srd(int a, bit any, output int got);
    bit ok = 1'b0;
    got = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rst_n && s_req && !s_we && !req &&
          (any || s_addr == AW'(a))) begin
        ok = 1'b1;
        got = int'(s_addr);
      end
    end
    chk("scrub_rd_timeout", ok, 1);
  endtask

  initial begin
    int n0;
    int got;
    bit ok;
    // Reset state
    repeat (3) cyc();
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_sram_req", s_req, 0);
    chk("rst_corr", corr_cnt, 0);
    chk("rst_uncorr_cnt", unc_cnt, 0);
    chk("rst_uncorr", unc, 0);
    chk("rst_pass", pass, 0);
    rst_n = 1'b1;
    scrub_en = 1'b1;

    // Clean pass: 8 reads, no writes, one pass_done
    wait_pass();
    chk("p1_reads", n_rd, 8);
    chk("p1_pass_cnt", n_pass, 1);
    chk("p1_corr", corr_cnt, 0);

    // Single-copy upset at 3, triple disagreement at 5
    cyc();
    inject(1, 3, 64'hFF);
    inject(0, 5, 64'h1);
    inject(1, 5, 64'h2);
    inject(2, 5, 64'h4);
    exp_wr.push_back('{a: 3'd3, d: 64'h0, be: 8'hFF});
    wait_pass();
    chk("p2_corr", corr_cnt, 1);
    chk("p2_uncorr_cnt", unc_cnt, 1);
    chk("p2_uncorr_pulses", n_unc, 1);
    chk("p2_wb_seen", exp_wr.size(), 0);
    chk("p2_pass_cnt", n_pass, 2);

    // Repair 5 by hand; next pass must be clean
    cyc();
    inject(0, 5, 64'h0);
    inject(1, 5, 64'h0);
    inject(2, 5, 64'h0);
    wait_pass();
    chk("p3_corr", corr_cnt, 1);
    chk("p3_uncorr_cnt", unc_cnt, 1);
    chk("p3_uncorr_pulses", n_unc, 1);

    // Client writes incl. partial byte enables, then 20-cycle hold
    cyc();
    cli(1, 1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
    cli(1, 2, 64'h01234567_89ABCDEF, 8'hFF, 0);
    cli(1, 2, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 0);
    n0 = n_rd;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) cli(0, 1, 0, 0, 64'hDEADBEEF_CAFEF00D);
      else            cli(0, 2, 0, 0, 64'h01234567_FFFFFFFF);
    end
    #1;
    chk("hold_no_scrub", n_rd - n0, 0);
    chk("rel_scrub_req", s_req, 1);
    chk("rel_scrub_we", s_we, 0);
    cyc();
    cyc();

    // Disabled scrubber stays quiet; client vote path
    scrub_en = 1'b0;
    repeat (10) cyc();
    n0 = n_rd;
    repeat (20) cyc();
    chk("disabled_no_reads", n_rd - n0, 0);
    inject(0, 5, 64'h0F);
    inject(1, 5, 64'h3C);
    inject(2, 5, 64'hF0);
    cli(0, 5, 0, 0, 64'h3C);
    cli(1, 5, 64'h0, 8'hFF, 0);
    cyc();
    cyc();
    chk("disabled_uncorr_cnt", unc_cnt, 1);
    scrub_en = 1'b1;

    // WB cancelled by client write to the same address
    inject(2, 6, 64'h5);
    wait_srd(6, 1'b0, got);
    cyc();
    cli(1, 0, 64'h0, 8'hFF, 0);
    cli(1, 6, 64'hAA, 8'hFF, 0);
    repeat (4) cyc();
    chk("wbc_corr", corr_cnt, 1);
    cli(0, 6, 0, 0, 64'hAA);
    cyc();
    chk("wbc_no_wr_pending", exp_wr.size(), 0);
    chk("wbc_uncorr_cnt", unc_cnt, 1);

    // Reset while held in WB; next pass repairs the word
    inject(0, 4, 64'h77);
    wait_srd(4, 1'b0, got);
    cyc();
    cli(1, 0, 64'h0, 8'hFF, 0);
    cli(1, 0, 64'h0, 8'hFF, 0);
    rst_n = 1'b0;
    #1;
    chk("wbr_corr", corr_cnt, 0);
    chk("wbr_uncorr_cnt", unc_cnt, 0);
    chk("wbr_sram_req", s_req, 0);
    chk("wbr_sram_we", s_we, 0);
    chk("wbr_rvalid", rvalid, 0);
    chk("wbr_pass", pass, 0);
    exp_wr.push_back('{a: 3'd4, d: 64'h0, be: 8'hFF});
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_srd(0, 1'b1, got);
    chk("wbr_first_addr", got, 0);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (exp_wr.size() == 0) ok = 1'b1;
    end
    #1;
    chk("wbr_repair_seen", ok, 1);
    cyc();
    chk("wbr_corr_after", corr_cnt, 1);

    repeat (3) cyc();
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
